// File: rtl/addr_gen_if.sv
// addr_gen_if: control-unit to address-generator bus (mode inputs, address and stack status outputs)
interface addr_gen_if #(parameter int AW = 8);
  logic          en;
  logic [2:0]    modo;
  logic [AW-1:0] pcout;
  logic [AW-1:0] ix;
  logic [AW-1:0] disp;
  logic          clr_err;
  logic [AW-1:0] direccion;
  logic          valido;
  logic [AW-1:0] sp;
  logic          pila_vacia;
  logic          pila_llena;
  logic          err_pila;
  modport master (output en, modo, pcout, ix, disp, clr_err,
                  input direccion, valido, sp, pila_vacia, pila_llena, err_pila);
  modport slave  (input en, modo, pcout, ix, disp, clr_err,
                  output direccion, valido, sp, pila_vacia, pila_llena, err_pila);
endinterface

// File: rtl/addr_gen.sv
// addr_gen: registered memory-address generator with stack pointer and auto-index register
module addr_gen #(
  parameter int          AW      = 8,
  parameter logic [AW-1:0] SP_INIT = 8'hFF,
  parameter logic [AW-1:0] SP_MIN  = 8'hC0
) (
  input  logic       clk,
  input  logic       rst_n,
  addr_gen_if.slave  bus
);
  logic [AW-1:0] dir_q, dir_d, sp_q, sp_d, ixa_q, ixa_d;
  logic          valido_q, valido_d, err_q, err_d, full, empty, err_set;
  assign full  = sp_q == SP_MIN;
  assign empty = sp_q == SP_INIT;
  always_comb begin
    dir_d    = dir_q;
    valido_d = 1'b0;
    sp_d     = sp_q;
    ixa_d    = ixa_q;
    err_set  = 1'b0;
    if (bus.en) begin
      case (bus.modo)
        3'd0: begin dir_d = bus.pcout; valido_d = 1'b1; end
        3'd1: begin dir_d = bus.ix; valido_d = 1'b1; end
        3'd2: begin dir_d = bus.ix + bus.disp; valido_d = 1'b1; end
        3'd3: begin dir_d = ixa_q; ixa_d = ixa_q + 1'b1; valido_d = 1'b1; end
        3'd4: begin
          err_set  = full;
          sp_d     = full ? sp_q : sp_q - 1'b1;
          dir_d    = full ? dir_q : sp_q - 1'b1;
          valido_d = ~full;
        end
        3'd5: begin
          err_set  = empty;
          sp_d     = empty ? sp_q : sp_q + 1'b1;
          dir_d    = empty ? dir_q : sp_q;
          valido_d = ~empty;
        end
        3'd6: ixa_d = bus.ix;
        default: ;
      endcase
    end
    // a new error in the same cycle wins over a clear request
    err_d = err_set | (err_q & ~bus.clr_err);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_q    <= '0;
      valido_q <= 1'b0;
      sp_q     <= SP_INIT;
      ixa_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      dir_q    <= dir_d;
      valido_q <= valido_d;
      sp_q     <= sp_d;
      ixa_q    <= ixa_d;
      err_q    <= err_d;
    end
  end
  assign bus.direccion  = dir_q;
  assign bus.valido     = valido_q;
  assign bus.sp         = sp_q;
  assign bus.pila_vacia = empty;
  assign bus.pila_llena = full;
  assign bus.err_pila   = err_q;
endmodule

// File: doc/addr_gen.md
# addr_gen

Parametrised, registered memory-address generator for the Von Neumann core, and the successor of the two-way PC/IX address selector. Each enabled cycle it selects one of eight addressing modes (PC, IX, IX+displacement, auto-incrementing index, stack push/pop, index load, hold). It drives a registered `direccion` to the unified memory. It owns the stack pointer and an auto-index register, and reports stack full, stack empty and sticky stack-error status to the control unit.

## Interface
Parameters:
- `AW`, 8, address/data width of all address paths.
- `SP_INIT`, 8'hFF, stack pointer reset value (empty stack); must be > `SP_MIN`.
- `SP_MIN`, 8'hC0, lowest stack address (full stack); capacity = `SP_INIT - SP_MIN` entries.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  mode strobe; 0 = all state and `direccion` hold.
- `modo`  in  3  addressing mode, sampled when `en`=1.
- `pcout`  in  AW  program counter.
- `ix`  in  AW  index register.
- `disp`  in  AW  displacement, two's complement, modular add.
- `clr_err`  in  1  clears `err_pila`.
- `direccion`  out  AW  registered memory address.
- `valido`  out  1  one-cycle pulse: `direccion` holds a new access address.
- `sp`  out  AW  stack pointer register.
- `pila_vacia`  out  1  `sp == SP_INIT` (combinational from register).
- `pila_llena`  out  1  `sp == SP_MIN`.
- `err_pila`  out  1  sticky push-when-full / pop-when-empty flag.

## Operation
Modes (`en`=1), written to `direccion` at the next edge:
- 0 PC: `direccion`=`pcout`; `valido`=1.
- 1 IX: `direccion`=`ix`; `valido`=1.
- 2 IX+D: `direccion`=(`ix`+`disp`) mod 2^AW; `valido`=1.
- 3 IXA: `direccion`=`ixa`; `ixa`<=`ixa`+1, wrapping 2^AW-1→0; `valido`=1.
- 4 PUSH: if not full, `sp`<=`sp`-1 and `direccion`=`sp`-1 (pre-decrement), `valido`=1. If full, `sp` and `direccion` hold, `valido`=0, `err_pila`<=1.
- 5 POP: if not empty, `direccion`=`sp` and `sp`<=`sp`+1 (post-increment), `valido`=1. If empty, hold, `valido`=0, `err_pila`<=1.
- 6 LDIXA: `ixa`<=`ix`; `direccion` holds; `valido`=0.
- 7 HOLD: no state change; `valido`=0.

Control and status:
- `en`=0: every register holds and `valido`=0. `clr_err` is still honoured.
- `ixa` is internal (AW bits) and is not an output.
- `err_pila`: set has priority over `clr_err` in the same cycle. Once set, it stays set until `clr_err` or reset.
- Full/empty flags derive only from the `sp` register. They are never inferred from `modo`.

Reset (`rst_n`=0 at edge) overrides all inputs. Reset state:
- `direccion`=0, `valido`=0, `sp`=`SP_INIT`, `ixa`=0, `err_pila`=0.
- Therefore `pila_vacia`=1 and `pila_llena`=0.

## Timing
- Latency: `direccion` reflects inputs sampled at edge N from edge N onward (one register stage, as before). `valido` is aligned with `direccion`.
- `sp` update and `direccion` update for PUSH/POP land on the same edge.
- `pila_vacia`/`pila_llena` are valid in the cycle after the PUSH/POP edge.
- Back-to-back PUSH/POP each cycle is supported, with no bubble.
- PUSH immediately followed by POP returns the same address.
- Reset asserted mid-sequence takes effect at that edge. Any in-flight PUSH/POP is discarded.
- `valido` after reset deassertion stays 0 until the first enabled addressing mode.

## Test plan
- Reset, then `en`=1, `modo`=0, `pcout`=8'h12 → next edge `direccion`=8'h12 and `valido`=1. Then `modo`=1, `ix`=8'h34 → `direccion`=8'h34.
- `modo`=2, `ix`=8'hF0, `disp`=8'h20 → `direccion`=8'h10 (wrap). With `disp`=8'hFE → `direccion`=8'hEE.
- `modo`=6 with `ix`=8'hFE, then `modo`=3 for three cycles → `direccion` FE, FF, 00. `valido`=1 each cycle; `valido`=0 in the LDIXA cycle.
- From reset, PUSH ×2 → `direccion` FE, FD and `sp`=FD. Then POP ×2 → `direccion` FD, FE and `sp`=FF with `pila_vacia`=1. A further POP → `valido`=0, `sp`=FF, `err_pila`=1.
- PUSH ×63 → `sp`=C0 and `pila_llena`=1. 64th PUSH → `sp` stays C0, `err_pila`=1. Then `clr_err` together with another PUSH → `err_pila` stays 1. `clr_err` alone → `err_pila`=0.
- PUSH ×3, then `rst_n`=0 for one edge during a PUSH → `sp`=FF, `direccion`=0, `valido`=0. `en`=0 with `modo`=4 → no change.
